pipe_ctrl: RTL and testbench

Pipeline controller that drives the PC register's `jump`, `jump_addr` and `hold` inputs and the pipeline flush line. It arbitrates between redirect sources (EX branch/jump, interrupt entry, trap return) and stall sources (memory wait, multi-cycle divide). It also owns a one-entry pending-redirect buffer, the trap return address and a divide watchdog. It sits beside the PC in the core top level. Its outputs feed the PC and the IF/ID/EX pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_div_watchdog.sv | 29 ++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: control polarities, PC reset address and
// the controller state encodings.
package pipe_ctrl_pkg;

  localparam logic JUMP = 1'b1;
  localparam logic HOLD = 1'b1;
  localparam logic RST  = 1'b1;

  localparam int unsigned INI_ADDR_W = 32;
  localparam logic [INI_ADDR_W-1:0] INI_INST_ADDR = 32'h0000_0000;

  typedef enum logic {
    CTRL_IDLE     = 1'b0,
    CTRL_DIV_WAIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_div_watchdog.sv
// Divide watchdog: counts DIV_WAIT cycles and flags the final allowed cycle.
module div_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // High during the TIMEOUT-th cycle spent waiting.
  assign expire_c = en & (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates PC redirects against stalls, holds one
// pending redirect, the trap return address and the divide wait state.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_jump_req,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              mret_req,
  input  logic              irq_req,
  input  logic [ADDR_W-1:0] irq_vec,
  input  logic              mem_stall_req,
  input  logic              div_start,
  input  logic              div_done,
  output logic              jump_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              hold_o,
  output logic              flush_o,
  output logic              irq_ack_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              in_trap_o,
  output logic              div_err_o
);

  ctrl_state_t       state;
  logic              pend_v;
  logic              pend_mret;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] epc;
  logic              in_trap;

  logic              in_wait;
  logic              wd_expire;
  logic              in_reset;
  logic              hold_c;
  logic              take_irq;
  logic              take_pend;
  logic              take_mret;
  logic              take_jump;
  logic              redirect_c;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] irq_epc_c;

  assign in_wait  = (state == CTRL_DIV_WAIT);
  assign in_reset = (rst == RST);

  div_watchdog #(
    .TIMEOUT (DIV_TIMEOUT)
  ) u_div_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      ((state == CTRL_IDLE) & div_start),
    .en       (in_wait),
    .expire_c (wd_expire)
  );

  // Stall and redirect arbitration; redirects only happen when not held.
  always_comb begin
    hold_c     = mem_stall_req | div_start | (in_wait & ~div_done & ~wd_expire);
    take_irq   = ~hold_c & irq_req & ~in_trap;
    take_pend  = ~hold_c & ~take_irq & pend_v;
    take_mret  = ~hold_c & ~take_irq & ~pend_v & mret_req;
    take_jump  = ~hold_c & ~take_irq & ~pend_v & ~mret_req & ex_jump_req;
    redirect_c = take_irq | take_pend | take_mret | take_jump;
    target_c   = '0;
    if (take_irq) begin
      target_c = irq_vec;
    end else if (take_pend) begin
      target_c = pend_addr;
    end else if (take_mret) begin
      target_c = epc;
    end else if (take_jump) begin
      target_c = ex_jump_addr;
    end
    irq_epc_c = pend_v ? pend_addr : (ex_jump_req ? ex_jump_addr : ex_pc);
  end

  // Everything is forced low while reset is asserted.
  always_comb begin
    jump_o      = ~in_reset & redirect_c;
    jump_addr_o = in_reset ? '0 : target_c;
    hold_o      = ~in_reset & hold_c;
    flush_o     = ~in_reset & redirect_c;
    irq_ack_o   = ~in_reset & take_irq;
    epc_o       = in_reset ? '0 : epc;
    in_trap_o   = ~in_reset & in_trap;
    div_err_o   = ~in_reset & wd_expire & ~div_done;
  end

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state     <= CTRL_IDLE;
      pend_v    <= 1'b0;
      pend_mret <= 1'b0;
      pend_addr <= ADDR_W'(INI_INST_ADDR);
      epc       <= ADDR_W'(INI_INST_ADDR);
      in_trap   <= 1'b0;
    end else begin
      case (state)
        CTRL_IDLE:     if (div_start) state <= CTRL_DIV_WAIT;
        CTRL_DIV_WAIT: if (div_done | wd_expire) state <= CTRL_IDLE;
        default:       state <= CTRL_IDLE;
      endcase

      if (take_irq) begin
        epc     <= irq_epc_c;
        in_trap <= 1'b1;
        pend_v  <= 1'b0;
      end else if (take_pend) begin
        pend_v <= 1'b0;
        if (pend_mret) in_trap <= 1'b0;
      end else if (take_mret) begin
        in_trap <= 1'b0;
      end

      // Requests seen during a stall wait in the pending slot; mret wins.
      if (hold_c) begin
        if (mret_req) begin
          pend_v    <= 1'b1;
          pend_mret <= 1'b1;
          pend_addr <= epc;
        end else if (ex_jump_req) begin
          pend_v    <= 1'b1;
          pend_mret <= 1'b0;
          pend_addr <= ex_jump_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-level reference model and
// hand-computed expectations for the key scenarios.
module tb_pipe_ctrl;

  localparam int unsigned AW     = 32;
  localparam int unsigned DIV_TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_jump_req = 1'b0;
  logic [AW-1:0] ex_jump_addr = '0;
  logic [AW-1:0] ex_pc = '0;
  logic          mret_req = 1'b0;
  logic          irq_req = 1'b0;
  logic [AW-1:0] irq_vec = '0;
  logic          mem_stall_req = 1'b0;
  logic          div_start = 1'b0;
  logic          div_done = 1'b0;
  logic          jump_o;
  logic [AW-1:0] jump_addr_o;
  logic          hold_o;
  logic          flush_o;
  logic          irq_ack_o;
  logic [AW-1:0] epc_o;
  logic          in_trap_o;
  logic          div_err_o;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(
    .ADDR_W      (AW),
    .DIV_TIMEOUT (DIV_TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_jump_req   (ex_jump_req),
    .ex_jump_addr  (ex_jump_addr),
    .ex_pc         (ex_pc),
    .mret_req      (mret_req),
    .irq_req       (irq_req),
    .irq_vec       (irq_vec),
    .mem_stall_req (mem_stall_req),
    .div_start     (div_start),
    .div_done      (div_done),
    .jump_o        (jump_o),
    .jump_addr_o   (jump_addr_o),
    .hold_o        (hold_o),
    .flush_o       (flush_o),
    .irq_ack_o     (irq_ack_o),
    .epc_o         (epc_o),
    .in_trap_o     (in_trap_o),
    .div_err_o     (div_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: pending redirects, trap context, divide progress.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          is_mret;
  } pend_t;

  pend_t         pend_q[$];
  logic [AW-1:0] m_epc = '0;
  bit            m_in_trap = 1'b0;
  bit            m_div_active = 1'b0;
  int            m_wait = 0;

  always @(negedge clk) begin
    logic          e_hold, e_jump, e_ack, e_err, n_trap;
    logic [AW-1:0] e_addr, n_epc;
    if (rst) begin
      chk("rst_jump", 32'(jump_o), 32'd0);
      chk("rst_hold", 32'(hold_o), 32'd0);
      chk("rst_flush", 32'(flush_o), 32'd0);
      chk("rst_ack", 32'(irq_ack_o), 32'd0);
      chk("rst_err", 32'(div_err_o), 32'd0);
      chk("rst_epc", epc_o, 32'd0);
      chk("rst_trap", 32'(in_trap_o), 32'd0);
      pend_q.delete();
      m_epc = '0;
      m_in_trap = 1'b0;
      m_div_active = 1'b0;
      m_wait = 0;
    end else begin
      e_err  = m_div_active && !div_done && (m_wait == int'(DIV_TO));
      e_hold = mem_stall_req || div_start ||
               (m_div_active && !div_done && (m_wait != int'(DIV_TO)));
      e_jump = 1'b0;
      e_ack  = 1'b0;
      e_addr = '0;
      n_epc  = m_epc;
      n_trap = m_in_trap;
      if (!e_hold) begin
        if (irq_req && !m_in_trap) begin
          e_jump = 1'b1;
          e_ack  = 1'b1;
          e_addr = irq_vec;
          n_epc  = (pend_q.size() != 0) ? pend_q[0].addr :
                   (ex_jump_req ? ex_jump_addr : ex_pc);
          n_trap = 1'b1;
          pend_q.delete();
        end else if (pend_q.size() != 0) begin
          e_jump = 1'b1;
          e_addr = pend_q[0].addr;
          if (pend_q[0].is_mret) n_trap = 1'b0;
          pend_q.delete();
        end else if (mret_req) begin
          e_jump = 1'b1;
          e_addr = m_epc;
          n_trap = 1'b0;
        end else if (ex_jump_req) begin
          e_jump = 1'b1;
          e_addr = ex_jump_addr;
        end
      end else if (mret_req || ex_jump_req) begin
        assert (pend_q.size() == 0) else $error("protocol: request while pending");
        pend_q.delete();
        if (mret_req) pend_q.push_back('{addr: m_epc, is_mret: 1'b1});
        else          pend_q.push_back('{addr: ex_jump_addr, is_mret: 1'b0});
      end

      chk("jump", 32'(jump_o), 32'(e_jump));
      chk("flush", 32'(flush_o), 32'(e_jump));
      chk("hold", 32'(hold_o), 32'(e_hold));
      chk("irq_ack", 32'(irq_ack_o), 32'(e_ack));
      chk("div_err", 32'(div_err_o), 32'(e_err));
      chk("epc", epc_o, m_epc);
      chk("in_trap", 32'(in_trap_o), 32'(m_in_trap));
      if (e_jump) chk("jump_addr", jump_addr_o, e_addr);
      if (jump_o && hold_o) chk("jump_and_hold", 32'd1, 32'd0);

      m_epc     = n_epc;
      m_in_trap = n_trap;
      if (m_div_active) begin
        if (div_done || m_wait == int'(DIV_TO)) m_div_active = 1'b0;
        else m_wait++;
      end else if (div_start) begin
        m_div_active = 1'b1;
        m_wait = 1;
      end
    end
  end

  initial begin
    // Reset with active requests: everything must stay low.
    rst = 1'b1; mem_stall_req = 1'b1; ex_jump_req = 1'b1; ex_jump_addr = 32'h900; div_start = 1'b1;
    @(negedge clk);
    chk("L_rst_hold", 32'(hold_o), 32'd0);
    chk("L_rst_jump", 32'(jump_o), 32'd0);
    tick();
    tick();
    rst = 1'b0; mem_stall_req = 1'b0; ex_jump_req = 1'b0; div_start = 1'b0;
    @(negedge clk);
    chk("L_post_rst_hold", 32'(hold_o), 32'd0);
    chk("L_post_rst_epc", epc_o, 32'h0);
    tick();

    // Plain jump.
    ex_jump_req = 1'b1; ex_jump_addr = 32'h100;
    @(negedge clk);
    chk("L_plain_jump", 32'(jump_o), 32'd1);
    chk("L_plain_addr", jump_addr_o, 32'h100);
    chk("L_plain_flush", 32'(flush_o), 32'd1);
    chk("L_plain_hold", 32'(hold_o), 32'd0);
    tick();

    // Jump during a three-cycle memory stall.
    ex_jump_req = 1'b1; ex_jump_addr = 32'h200; mem_stall_req = 1'b1;
    @(negedge clk);
    chk("L_stall_jump1", 32'(jump_o), 32'd0);
    tick();
    ex_jump_req = 1'b0;
    @(negedge clk);
    chk("L_stall_jump2", 32'(jump_o), 32'd0);
    tick();
    @(negedge clk);
    chk("L_stall_jump3", 32'(jump_o), 32'd0);
    tick();
    mem_stall_req = 1'b0;
    @(negedge clk);
    chk("L_unstall_jump", 32'(jump_o), 32'd1);
    chk("L_unstall_addr", jump_addr_o, 32'h200);
    tick();
    @(negedge clk);
    chk("L_pend_cleared", 32'(jump_o), 32'd0);
    tick();

    // Interrupt entry and return.
    irq_req = 1'b1; irq_vec = 32'h40; ex_pc = 32'h80;
    @(negedge clk);
    chk("L_irq_addr", jump_addr_o, 32'h40);
    chk("L_irq_ack", 32'(irq_ack_o), 32'd1);
    tick();
    @(negedge clk);
    chk("L_irq_masked", 32'(jump_o), 32'd0);
    chk("L_irq_epc", epc_o, 32'h80);
    chk("L_irq_trap", 32'(in_trap_o), 32'd1);
    tick();
    irq_req = 1'b0; mret_req = 1'b1;
    @(negedge clk);
    chk("L_mret_addr", jump_addr_o, 32'h80);
    tick();
    mret_req = 1'b0;
    @(negedge clk);
    chk("L_mret_trap", 32'(in_trap_o), 32'd0);
    tick();

    // Interrupt wins over a concurrent branch; branch target is saved.
    irq_req = 1'b1; ex_jump_req = 1'b1; ex_jump_addr = 32'h300;
    @(negedge clk);
    chk("L_irq_vs_br_addr", jump_addr_o, 32'h40);
    tick();
    irq_req = 1'b0; ex_jump_req = 1'b0;
    @(negedge clk);
    chk("L_irq_vs_br_epc", epc_o, 32'h300);
    tick();
    mret_req = 1'b1;
    @(negedge clk);
    chk("L_ret_300", jump_addr_o, 32'h300);
    tick();
    mret_req = 1'b0;

    // Interrupt taken while a stalled jump is pending; stalled mret afterwards.
    mem_stall_req = 1'b1; ex_jump_req = 1'b1; ex_jump_addr = 32'h500;
    @(negedge clk);
    tick();
    mem_stall_req = 1'b0; ex_jump_req = 1'b0; irq_req = 1'b1; ex_pc = 32'h84;
    @(negedge clk);
    chk("L_pend_irq_addr", jump_addr_o, 32'h40);
    tick();
    irq_req = 1'b0; mem_stall_req = 1'b1; mret_req = 1'b1;
    @(negedge clk);
    chk("L_pend_irq_epc", epc_o, 32'h500);
    tick();
    mret_req = 1'b0; mem_stall_req = 1'b0;
    @(negedge clk);
    chk("L_pend_mret_addr", jump_addr_o, 32'h500);
    chk("L_pend_mret_jump", 32'(jump_o), 32'd1);
    tick();
    @(negedge clk);
    chk("L_pend_mret_trap", 32'(in_trap_o), 32'd0);
    tick();

    // Five-cycle divide with a jump latched during the wait.
    div_start = 1'b1;
    @(negedge clk);
    chk("L_div_start_hold", 32'(hold_o), 32'd1);
    tick();
    div_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ex_jump_req = (i == 2);
      ex_jump_addr = 32'h600;
      @(negedge clk);
      chk("L_div_wait_hold", 32'(hold_o), 32'd1);
      tick();
    end
    ex_jump_req = 1'b0; div_done = 1'b1;
    @(negedge clk);
    chk("L_div_done_hold", 32'(hold_o), 32'd0);
    chk("L_div_done_jump", jump_addr_o, 32'h600);
    tick();
    div_done = 1'b0;
    @(negedge clk);
    tick();

    // Divide timeout.
    div_start = 1'b1;
    @(negedge clk);
    tick();
    div_start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("L_to_wait_hold", 32'(hold_o), 32'd1);
      chk("L_to_wait_err", 32'(div_err_o), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("L_to_err", 32'(div_err_o), 32'd1);
    chk("L_to_hold", 32'(hold_o), 32'd0);
    tick();
    @(negedge clk);
    chk("L_to_idle_hold", 32'(hold_o), 32'd0);
    chk("L_to_idle_err", 32'(div_err_o), 32'd0);
    tick();

    // div_done in the timeout cycle is a normal exit.
    div_start = 1'b1;
    @(negedge clk);
    tick();
    div_start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      tick();
    end
    div_done = 1'b1;
    @(negedge clk);
    chk("L_done_at_to_err", 32'(div_err_o), 32'd0);
    chk("L_done_at_to_hold", 32'(hold_o), 32'd0);
    tick();
    div_done = 1'b0;

    // Reset mid-divide with a pending jump discards both.
    div_start = 1'b1;
    @(negedge clk);
    tick();
    div_start = 1'b0; ex_jump_req = 1'b1; ex_jump_addr = 32'h700;
    @(negedge clk);
    tick();
    ex_jump_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("L_rst_mid_hold", 32'(hold_o), 32'd0);
    chk("L_rst_mid_err", 32'(div_err_o), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("L_rst_mid_after_hold", 32'(hold_o), 32'd0);
    chk("L_rst_mid_after_jump", 32'(jump_o), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("L_rst_mid_no_err", 32'(div_err_o), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
